// File: rtl/result_dec_streamer.sv
// result_dec_streamer: captures a signed ALU result, converts it to BCD by double-dabble
// and streams it as ASCII ('-', digits without leading zeros, LF) over valid/ready.
module result_dec_streamer #(
    parameter int W      = 160,
    parameter int DIGITS = 49
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] res_in,
    input  logic         res_valid,
    output logic [7:0]   out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic         busy,
    output logic         overrun
);
    typedef enum logic [1:0] {IDLE, ABS, CONV, EMIT} state_t;
    state_t state, state_n;
    logic prev_valid, neg, sign_pend, term, rise, xfer;
    logic [W-1:0] mag, mag_n;
    logic [4*DIGITS-1:0] bcd, adj, bcd_n;
    logic [7:0] cnt;
    logic [5:0] idx, msd;
    assign rise      = res_valid & ~prev_valid;
    assign out_valid = state == EMIT;
    assign busy      = state != IDLE;
    assign xfer      = out_valid & out_ready;
    assign out_last  = out_valid & term;
    assign out_data  = !out_valid ? 8'h00 : sign_pend ? 8'h2D : term ? 8'h0A : {4'h3, bcd[4*idx +: 4]};
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = rise ? ABS : IDLE;
            ABS:     state_n = CONV;
            CONV:    state_n = (cnt == 8'(W-1)) ? EMIT : CONV;
            EMIT:    state_n = (xfer && term) ? IDLE : EMIT;
            default: state_n = IDLE;
        endcase
    end
    // One double-dabble step, plus the most significant non-zero digit of its result
    // so the emitter can start past the leading zeros.
    always_comb begin
        adj = bcd;
        for (int d = 0; d < DIGITS; d++)
            if (bcd[4*d +: 4] >= 4'd5) adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
        {bcd_n, mag_n} = {adj[4*DIGITS-2:0], mag, 1'b0};
        msd = '0;
        for (int i = 0; i < DIGITS; i++)
            if (bcd_n[4*i +: 4] != 4'd0) msd = 6'(i);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            prev_valid <= 1'b0;
            neg        <= 1'b0;
            sign_pend  <= 1'b0;
            term       <= 1'b0;
            mag        <= '0;
            bcd        <= '0;
            cnt        <= '0;
            idx        <= '0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_n;
            prev_valid <= res_valid;
            if (rise && state != IDLE) overrun <= 1'b1;
            case (state)
                IDLE: if (rise) begin
                    neg <= res_in[W-1];
                    mag <= res_in;
                end
                ABS: begin
                    mag <= neg ? -mag : mag;
                    bcd <= '0;
                    cnt <= '0;
                end
                CONV: begin
                    mag <= mag_n;
                    bcd <= bcd_n;
                    cnt <= cnt + 8'd1;
                    if (cnt == 8'(W-1)) begin
                        sign_pend <= neg;
                        term      <= 1'b0;
                        idx       <= msd;
                    end
                end
                EMIT: if (xfer) begin
                    if (sign_pend) sign_pend <= 1'b0;
                    else if (!term) begin
                        if (idx == 6'd0) term <= 1'b1;
                        else idx <= idx - 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_result_dec_streamer.sv
// tb_result_dec_streamer: directed runs checked against a decimal-string model of the
// result plus literal expectations for each streamed line.
module tb_result_dec_streamer;
    logic clk = 1'b0, rst = 1'b1, res_valid = 1'b0, out_ready = 1'b1;
    logic [159:0] res_in = '0;
    logic [7:0] out_data;
    logic out_valid, out_last, busy, overrun;
    int checks = 0, errors = 0, cyc = 0, first_cyc = 0;
    bit first_seen = 0, held = 0, h_last;
    logic [7:0] h_data;
    logic [7:0] exp_q[$];
    logic [7:0] got[$];

    result_dec_streamer dut (
        .clk(clk), .rst(rst), .res_in(res_in), .res_valid(res_valid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected text: sign, decimal magnitude by repeated division, then LF.
    function automatic string model(input logic [159:0] v);
        logic [159:0] m;
        string s = "";
        m = v[159] ? -v : v;
        do begin
            s = $sformatf("%0d%s", 32'(m % 10), s);
            m = m / 10;
        end while (m != 0);
        return {v[159] ? "-" : "", s, "\n"};
    endfunction

    function automatic string vis(input string s);
        string r = "";
        for (int i = 0; i < s.len(); i++) r = {r, (s[i] == 8'h0A) ? "|" : $sformatf("%c", s[i])};
        return r;
    endfunction

    function automatic string q2s();
        string r = "";
        foreach (got[i]) r = {r, $sformatf("%c", got[i])};
        return r;
    endfunction

    function automatic void chk(input string n, input logic [63:0] a, input logic [63:0] r);
        checks++;
        if (a !== r) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", n, a, r);
        end
    endfunction

    function automatic void chk_s(input string n, input string a, input string r);
        checks++;
        if (a != r) begin
            errors++;
            $display("FAIL %s actual=%s required=%s", n, vis(a), vis(r));
        end
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            held = 0;
        end else begin
            if (held) begin
                checks++;
                if (!out_valid || out_data !== h_data || out_last !== h_last) begin
                    errors++;
                    $display("FAIL hold actual=%0b/%0h/%0b required=1/%0h/%0b", out_valid, out_data, out_last, h_data, h_last);
                end
            end
            if (out_valid) begin
                if (!first_seen) begin
                    first_seen = 1;
                    first_cyc = cyc;
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_byte actual=%0h required=none", out_data);
                end else if (out_data !== exp_q[0] || out_last !== (exp_q.size() == 1)) begin
                    errors++;
                    $display("FAIL byte actual=%0h last=%0b required=%0h last=%0b", out_data, out_last, exp_q[0], exp_q.size() == 1);
                end
                if (out_ready) begin
                    got.push_back(out_data);
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                end
            end
            held = out_valid & ~out_ready;
            h_data = out_data;
            h_last = out_last;
        end
    end

    task automatic start(input logic [159:0] v, input string lit);
        string m;
        int t0;
        m = model(v);
        chk_s("model", m, lit);
        for (int i = 0; i < m.len(); i++) exp_q.push_back(m[i]);
        got.delete();
        first_seen = 0;
        @(posedge clk); #1;
        res_in = v;
        res_valid = 1'b1;
        t0 = cyc;
        @(negedge clk);
        @(negedge clk);
        chk("busy_after_capture", busy, 1);
    endtask

    task automatic run(input logic [159:0] v, input string lit, input bit stall, input bit intrude);
        int n, t0;
        start(v, lit);
        t0 = cyc - 1;
        repeat (3) @(posedge clk);
        #1 res_valid = 1'b0;
        if (intrude) begin
            repeat (15) @(posedge clk);
            #1 res_in = 160'd1;
            res_valid = 1'b1;
            @(posedge clk); #1 res_valid = 1'b0;
            @(negedge clk);
            chk("overrun_set", overrun, 1);
        end
        n = 0;
        while (!first_seen && n < 300) begin
            @(posedge clk);
            n++;
        end
        chk("latency", 64'(first_cyc - t0), 162);
        if (stall) begin
            @(posedge clk); #1 out_ready = 1'b0;
            repeat (5) @(posedge clk);
            #1 out_ready = 1'b1;
        end
        n = 0;
        while ((busy || exp_q.size() != 0) && n < 400) begin
            @(posedge clk);
            n++;
        end
        chk("finished", 64'(n < 400), 1);
        @(negedge clk);
        chk("idle_busy", {busy, out_valid}, 0);
        chk_s("stream", q2s(), lit);
    endtask

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_outputs", {out_valid, out_data, out_last, busy, overrun}, 0);
        run(160'd12345, "12345\n", 0, 0);
        run(-160'sd7, "-7\n", 0, 0);
        run(160'd0, "0\n", 0, 0);
        run(160'd1 << 159, "-730750818665451459101842416358141509827966271488\n", 0, 0);
        run((160'd1 << 159) - 160'd1, "730750818665451459101842416358141509827966271487\n", 0, 0);
        run(160'd905, "905\n", 1, 0);
        run(160'd12345, "12345\n", 0, 1);
        run(160'd1, "1\n", 0, 0);
        chk("overrun_sticky", overrun, 1);
        out_ready = 1'b0;
        start(160'd12345, "12345\n");
        @(posedge clk); #1 res_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 300) begin
            @(posedge clk);
            n++;
        end
        chk("reached_emit", out_valid, 1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("rst_mid_emit", {out_valid, out_data, out_last, busy, overrun}, 0);
        run(160'd42, "42\n", 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
